regfile_bypass_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_bypass_sb.sv | 126 ++++++++++++
 tb/tb_regfile_bypass_sb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port priority match used by the
// register file top level (write merge and same-cycle bypass).
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;

    // The match function works on fixed-size widened vectors so that any
    // instance with NWR <= MAX_WR and ADDR_W <= MAX_ADDR_W can share it.
    localparam int unsigned MAX_WR     = 8;
    localparam int unsigned MAX_ADDR_W = 8;
    localparam int unsigned PORT_IDX_W = $clog2(MAX_WR);

    typedef logic [MAX_ADDR_W-1:0]             addr_t;
    typedef logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_addr_vec_t;

    typedef struct packed {
        logic                  hit;
        logic [PORT_IDX_W-1:0] port;
    } wr_match_t;

    // Highest-index enabled write port whose address equals addr.
    // Ascending scan: a later (higher) match overwrites an earlier one.
    function automatic wr_match_t wr_prio_match(
        input logic [MAX_WR-1:0] en,
        input wr_addr_vec_t      addrs,
        input addr_t             addr
    );
        wr_match_t m;
        m = '0;
        for (int unsigned i = 0; i < MAX_WR; i++) begin
            if (en[i] && (addrs[i] == addr)) begin
                m.hit  = 1'b1;
                m.port = PORT_IDX_W'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard and write-collision detector.
//   clk, rst_n      : clock, async active-low reset
//   wr_en/wr_addr   : writeback ports (packed addresses), clear busy bits
//   rsv_en/rsv_addr : issue-time reservation, sets a busy bit
//   busy_vec        : registered busy state, one bit per register
//   wr_collide      : registered pulse, two or more enabled writes share an address
module regfile_scoreboard #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic                    wr_collide
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [NREGS-1:0] busy_nxt;
    logic             collide;

    // Reservation wins over a same-cycle retire: the new producer owns the register.
    always_comb begin
        busy_nxt = busy_vec;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (rsv_en && (rsv_addr == ADDR_W'(r))) begin
                busy_nxt[r] = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                        busy_nxt[r] = 1'b0;
                    end
                end
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Pairwise address compare; writes to a hardwired zero register are dropped
    // anyway, so they never count as a collision.
    always_comb begin
        collide = 1'b0;
        for (int unsigned i = 0; i < NWR; i++) begin
            for (int unsigned j = i + 1; j < NWR; j++) begin
                if (wr_en[i] && wr_en[j] &&
                    (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]) &&
                    !((ZERO_REG != 0) && (wr_addr[i*ADDR_W +: ADDR_W] == '0))) begin
                    collide = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec   <= '0;
            wr_collide <= 1'b0;
        end else begin
            busy_vec   <= busy_nxt;
            wr_collide <= collide;
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with hardwired-zero register, same-cycle
// write-to-read bypass, async clear and busy scoreboard.
//   clk, rst_n            : clock, async active-low reset
//   rd_addr               : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data, rd_busy      : combinational read data / busy per read port
//   wr_en/wr_addr/wr_data : packed write ports, higher index wins on collision
//   rsv_en, rsv_addr      : reserve a destination register at issue
//   busy_vec              : registered scoreboard state
//   wr_collide            : registered write-collision pulse
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic                    wr_collide
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0]     mem     [NREGS];
    logic [MAX_WR-1:0]     wen_x;
    wr_addr_vec_t          waddr_x;
    logic [DATA_W-1:0]     wdat    [MAX_WR];
    logic                  wr_hit  [NREGS];
    logic [PORT_IDX_W-1:0] wr_port [NREGS];
    wr_match_t             wm;
    wr_match_t             bm;
    logic [ADDR_W-1:0]     ra;

    // Widen write ports to the package match width; enables are masked during
    // reset so nothing is written or forwarded while rst_n is low.
    always_comb begin
        wen_x   = '0;
        waddr_x = '0;
        for (int unsigned i = 0; i < MAX_WR; i++) begin
            wdat[i] = '0;
        end
        for (int unsigned i = 0; i < NWR; i++) begin
            wen_x[i]   = wr_en[i] & rst_n;
            waddr_x[i] = MAX_ADDR_W'(wr_addr[i*ADDR_W +: ADDR_W]);
            wdat[i]    = wr_data[i*DATA_W +: DATA_W];
        end
    end

    // Per-register write merge: winning port for each register.
    always_comb begin
        wm = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            wm         = wr_prio_match(wen_x, waddr_x, MAX_ADDR_W'(r));
            wr_hit[r]  = wm.hit;
            wr_port[r] = wm.port;
        end
    end

    // Storage update; register 0 is never written when hardwired to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (wr_hit[r] && !((ZERO_REG != 0) && (r == 0))) begin
                    mem[r] <= wdat[wr_port[r]];
                end
            end
        end
    end

    // Read muxing: zero register, then bypass, then stored value with busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        bm      = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            bm = '0;
            if (BYPASS != 0) begin
                bm = wr_prio_match(wen_x, waddr_x, MAX_ADDR_W'(ra));
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
                rd_busy[p]                  = 1'b0;
            end else if (bm.hit) begin
                rd_data[p*DATA_W +: DATA_W] = wdat[bm.port];
                rd_busy[p]                  = 1'b0;
            end else begin
                rd_data[p*DATA_W +: DATA_W] = mem[ra];
                rd_busy[p]                  = busy_vec[ra];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_vec   (busy_vec),
        .wr_collide (wr_collide)
    );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench: default-parameter instance (a) plus a sweep instance (b)
// with NRD=3, NWR=1, DATA_W=32, ADDR_W=4, BYPASS=0.
module tb_regfile_bypass_sb;

    logic clk;
    logic rst_n;

    // Instance a: defaults
    logic [5:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic [1:0]  wr_en_a;
    logic [5:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic        rsv_en_a;
    logic [2:0]  rsv_addr_a;
    logic [7:0]  busy_vec_a;
    logic        wr_collide_a;

    // Instance b: sweep
    logic [11:0] rd_addr_b;
    logic [95:0] rd_data_b;
    logic [2:0]  rd_busy_b;
    logic [0:0]  wr_en_b;
    logic [3:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic        rsv_en_b;
    logic [3:0]  rsv_addr_b;
    logic [15:0] busy_vec_b;
    logic        wr_collide_b;

    int errors;
    int checks;

    regfile_bypass_sb dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr_a),
        .rd_data    (rd_data_a),
        .rd_busy    (rd_busy_a),
        .wr_en      (wr_en_a),
        .wr_addr    (wr_addr_a),
        .wr_data    (wr_data_a),
        .rsv_en     (rsv_en_a),
        .rsv_addr   (rsv_addr_a),
        .busy_vec   (busy_vec_a),
        .wr_collide (wr_collide_a)
    );

    regfile_bypass_sb #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .NRD      (3),
        .NWR      (1),
        .ZERO_REG (1),
        .BYPASS   (0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr_b),
        .rd_data    (rd_data_b),
        .rd_busy    (rd_busy_b),
        .wr_en      (wr_en_b),
        .wr_addr    (wr_addr_b),
        .wr_data    (wr_data_b),
        .rsv_en     (rsv_en_b),
        .rsv_addr   (rsv_addr_b),
        .busy_vec   (busy_vec_b),
        .wr_collide (wr_collide_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all inputs of instance a in one go.
    task automatic drive_a(input logic [1:0] wen,
                           input logic [2:0] a0, input logic [15:0] d0,
                           input logic [2:0] a1, input logic [15:0] d1,
                           input logic [2:0] r0, input logic [2:0] r1,
                           input logic rsv, input logic [2:0] rsva);
        wr_en_a    = wen;
        wr_addr_a  = {a1, a0};
        wr_data_a  = {d1, d0};
        rd_addr_a  = {r1, r0};
        rsv_en_a   = rsv;
        rsv_addr_a = rsva;
    endtask

    task automatic test_reset_init();
        #3;
        checks++;
        if (busy_vec_a !== 8'h00) begin
            errors++; $display("FAIL init_busy: got %h expected 00", busy_vec_a);
        end
        checks++;
        if (wr_collide_a !== 1'b0) begin
            errors++; $display("FAIL init_collide: got %b expected 0", wr_collide_a);
        end
        checks++;
        if (rd_data_a !== 32'h0) begin
            errors++; $display("FAIL init_rd: got %h expected 00000000", rd_data_a);
        end
        checks++;
        if (busy_vec_b !== 16'h0) begin
            errors++; $display("FAIL init_busy_b: got %h expected 0000", busy_vec_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_a(2'b01, 3'd3, 16'hBEEF, 3'd0, 16'h0, 3'd3, 3'd6, 1'b1, 3'd6);
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd3, 3'd6, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a[15:0] !== 16'hBEEF) begin
            errors++; $display("FAIL rst_pre_data: got %h expected beef", rd_data_a[15:0]);
        end
        checks++;
        if (busy_vec_a !== 8'h40 || rd_busy_a !== 2'b10) begin
            errors++; $display("FAIL rst_pre_busy: got %h/%b expected 40/10", busy_vec_a, rd_busy_a);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data_a[15:0] !== 16'h0000) begin
            errors++; $display("FAIL rst_async_data: got %h expected 0000", rd_data_a[15:0]);
        end
        checks++;
        if (busy_vec_a !== 8'h00 || rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL rst_async_busy: got %h/%b expected 00/00", busy_vec_a, rd_busy_a);
        end
        // Writes and reservations held across an edge during reset are ignored.
        drive_a(2'b01, 3'd1, 16'h5A5A, 3'd0, 16'h0, 3'd1, 3'd1, 1'b1, 3'd1);
        @(posedge clk);
        #1;
        checks++;
        if (rd_data_a[15:0] !== 16'h0000 || busy_vec_a !== 8'h00) begin
            errors++; $display("FAIL rst_hold: got %h/%h expected 0000/00", rd_data_a[15:0], busy_vec_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd1, 3'd3, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h0) begin
            errors++; $display("FAIL rst_after: got %h expected 00000000", rd_data_a);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive_a(2'b11, 3'd0, 16'h1234, 3'd0, 16'h1111, 3'd0, 3'd0, 1'b1, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h0 || rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL zero_rd: got %h/%b expected 00000000/00", rd_data_a, rd_busy_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_vec_a !== 8'h00) begin
            errors++; $display("FAIL zero_busy: got %h expected 00", busy_vec_a);
        end
        checks++;
        if (wr_collide_a !== 1'b0) begin
            errors++; $display("FAIL zero_collide: got %b expected 0", wr_collide_a);
        end
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h0) begin
            errors++; $display("FAIL zero_stored: got %h expected 00000000", rd_data_a);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive_a(2'b11, 3'd5, 16'h00AA, 3'd5, 16'h0055, 3'd5, 3'd5, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h0055_0055 || rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL byp_prio: got %h/%b expected 00550055/00", rd_data_a, rd_busy_a);
        end
        checks++;
        if (wr_collide_a !== 1'b0) begin
            errors++; $display("FAIL byp_collide_pre: got %b expected 0", wr_collide_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_collide_a !== 1'b1) begin
            errors++; $display("FAIL byp_collide_pulse: got %b expected 1", wr_collide_a);
        end
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd5, 3'd0, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a[15:0] !== 16'h0055) begin
            errors++; $display("FAIL byp_stored: got %h expected 0055", rd_data_a[15:0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_collide_a !== 1'b0) begin
            errors++; $display("FAIL byp_collide_end: got %b expected 0", wr_collide_a);
        end
        // Distinct addresses on both ports, each forwarded to its own reader.
        @(negedge clk);
        drive_a(2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222, 3'd1, 3'd2, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h2222_1111) begin
            errors++; $display("FAIL byp_distinct: got %h expected 22221111", rd_data_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_collide_a !== 1'b0) begin
            errors++; $display("FAIL byp_distinct_collide: got %b expected 0", wr_collide_a);
        end
        // A disabled higher port with the same address must not win.
        @(negedge clk);
        drive_a(2'b01, 3'd6, 16'h6666, 3'd6, 16'h9999, 3'd6, 3'd1, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h1111_6666) begin
            errors++; $display("FAIL byp_disabled: got %h expected 11116666", rd_data_a);
        end
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd6, 3'd2, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h2222_6666 || wr_collide_a !== 1'b0) begin
            errors++; $display("FAIL byp_disabled_stored: got %h/%b expected 22226666/0", rd_data_a, wr_collide_a);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b1, 3'd2);
        #2;
        checks++;
        if (rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL sb_no_comb: got %b expected 00", rd_busy_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_vec_a !== 8'h04) begin
            errors++; $display("FAIL sb_set: got %h expected 04", busy_vec_a);
        end
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd2, 3'd1, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_busy_a !== 2'b01) begin
            errors++; $display("FAIL sb_rd_busy: got %b expected 01", rd_busy_a);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy_vec_a !== 8'h04) begin
            errors++; $display("FAIL sb_hold: got %h expected 04", busy_vec_a);
        end
        drive_a(2'b10, 3'd0, 16'h0, 3'd2, 16'h7777, 3'd2, 3'd2, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a !== 32'h7777_7777 || rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL sb_wr_bypass: got %h/%b expected 77777777/00", rd_data_a, rd_busy_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_vec_a !== 8'h00) begin
            errors++; $display("FAIL sb_clear: got %h expected 00", busy_vec_a);
        end
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a[15:0] !== 16'h7777 || rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL sb_stored: got %h/%b expected 7777/00", rd_data_a[15:0], rd_busy_a);
        end
    endtask

    task automatic test_race();
        @(negedge clk);
        drive_a(2'b01, 3'd4, 16'h0101, 3'd0, 16'h0, 3'd4, 3'd0, 1'b1, 3'd4);
        @(posedge clk);
        #1;
        checks++;
        if (busy_vec_a !== 8'h10) begin
            errors++; $display("FAIL race_busy: got %h expected 10", busy_vec_a);
        end
        @(negedge clk);
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0, 3'd0);
        #2;
        checks++;
        if (rd_data_a[15:0] !== 16'h0101 || rd_busy_a[0] !== 1'b1) begin
            errors++; $display("FAIL race_read: got %h/%b expected 0101/1", rd_data_a[15:0], rd_busy_a[0]);
        end
        @(negedge clk);
        drive_a(2'b10, 3'd0, 16'h0, 3'd4, 16'h0202, 3'd4, 3'd0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        checks++;
        if (busy_vec_a !== 8'h00) begin
            errors++; $display("FAIL race_retire: got %h expected 00", busy_vec_a);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] mdl [16];
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        we;
        logic [3:0]  ra [3];
        for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wa = 4'((i * 7 + 3) % 16);
            wd = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
            we = ((i % 4) != 3);
            ra[0] = wa;
            ra[1] = 4'((i * 5) % 16);
            ra[2] = 4'((i * 3 + 1) % 16);
            wr_en_b   = we;
            wr_addr_b = wa;
            wr_data_b = wd;
            rd_addr_b = {ra[2], ra[1], ra[0]};
            #2;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (rd_data_b[p*32 +: 32] !== mdl[ra[p]]) begin
                    errors++;
                    $display("FAIL sweep_rd i=%0d p=%0d addr=%0d: got %h expected %h",
                             i, p, ra[p], rd_data_b[p*32 +: 32], mdl[ra[p]]);
                end
            end
            @(posedge clk);
            if (we && wa != 4'd0) mdl[wa] = wd;
        end
        @(negedge clk);
        wr_en_b = 1'b0;
        #2;
        checks++;
        if (busy_vec_b !== 16'h0 || rd_busy_b !== 3'b000 || wr_collide_b !== 1'b0) begin
            errors++; $display("FAIL sweep_sb: got %h/%b/%b expected 0000/000/0", busy_vec_b, rd_busy_b, wr_collide_b);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive_a(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd3, 3'd5, 1'b0, 3'd0);
        rd_addr_b  = '0;
        wr_en_b    = '0;
        wr_addr_b  = '0;
        wr_data_b  = '0;
        rsv_en_b   = 1'b0;
        rsv_addr_b = '0;

        test_reset_init();
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_race();
        test_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
